// File: rtl/alu_muldiv_if.sv
// Request/result bundle between the control unit and the iterative multiply/divide unit.
// The control unit drives through the master modport; the unit itself uses the slave modport.
interface alu_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] reg2;
    logic [WIDTH-1:0] reg3;
    logic             ready;
    logic             result_valid;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             carry_out;
    logic             zero_out;
    logic             neg_out;
    logic             over_out;

    modport master (
        output start, op, reg2, reg3,
        input  ready, result_valid, result_lo, result_hi,
        input  carry_out, zero_out, neg_out, over_out
    );

    modport slave (
        input  start, op, reg2, reg3,
        output ready, result_valid, result_lo, result_hi,
        output carry_out, zero_out, neg_out, over_out
    );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative signed/unsigned multiply (double-width product) and divide (quotient + remainder),
// one bit per clock on operand magnitudes, with a sign fix-up cycle before results are published.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    alu_muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0]       OP_DIVS = 2'd3;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_reg;
    logic [CW-1:0]    count_reg;
    logic             signed_reg;
    logic             is_div_reg;
    logic             neg_x_reg;
    logic             neg_y_reg;
    logic             ovf_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] res_lo_reg;
    logic [WIDTH-1:0] res_hi_reg;
    logic             carry_reg;
    logic             zero_reg;
    logic             neg_reg;
    logic             over_reg;

    logic             ready_w;
    logic             accept;
    logic             in_neg_x;
    logic             in_neg_y;
    logic [WIDTH-1:0] in_x_mag;
    logic [WIDTH-1:0] in_y_mag;
    logic [WIDTH-1:0] mul_addend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   div_diff;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0] quo_fixed;
    logic [WIDTH-1:0] rem_fixed;
    logic [WIDTH-1:0] fix_lo;
    logic [WIDTH-1:0] fix_hi;
    logic             fix_c;
    logic             fix_z;
    logic             fix_n;
    logic             fix_v;

    assign ready_w = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
    assign accept  = bus.start && ready_w;

    // Magnitudes are taken on the accept edge so the iteration itself is purely unsigned.
    always_comb begin
        in_neg_x = bus.op[0] & bus.reg2[WIDTH-1];
        in_neg_y = bus.op[0] & bus.reg3[WIDTH-1];
        in_x_mag = in_neg_x ? -bus.reg2 : bus.reg2;
        in_y_mag = in_neg_y ? -bus.reg3 : bus.reg3;
    end

    // Multiply: {hi,lo} shifts right, adding the multiplicand into hi when lo[0] is set.
    // Divide: restoring step, quotient bits shift into lo as dividend bits shift out.
    always_comb begin
        mul_addend = lo_reg[0] ? a_reg : '0;
        mul_sum    = {1'b0, hi_reg} + {1'b0, mul_addend};
        rem_shift  = {hi_reg, lo_reg[WIDTH-1]};
        div_diff   = rem_shift - {1'b0, a_reg};
    end

    always_comb begin
        prod_mag   = {hi_reg, lo_reg};
        prod_fixed = (neg_x_reg ^ neg_y_reg) ? -prod_mag : prod_mag;
        quo_fixed  = (neg_x_reg ^ neg_y_reg) ? -lo_reg : lo_reg;
        rem_fixed  = neg_x_reg ? -hi_reg : hi_reg;
        fix_lo = '0;
        fix_hi = '0;
        fix_c  = 1'b0;
        fix_z  = 1'b0;
        fix_n  = 1'b0;
        fix_v  = 1'b0;
        if (is_div_reg) begin
            fix_lo = ovf_reg ? MIN_VAL : quo_fixed;
            fix_hi = ovf_reg ? '0 : rem_fixed;
            fix_z  = (fix_lo == '0);
            fix_n  = fix_lo[WIDTH-1];
            fix_v  = ovf_reg;
        end else begin
            fix_lo = prod_fixed[WIDTH-1:0];
            fix_hi = prod_fixed[2*WIDTH-1:WIDTH];
            fix_c  = signed_reg ? (fix_hi != {WIDTH{fix_lo[WIDTH-1]}}) : (fix_hi != '0);
            fix_z  = (prod_fixed == '0);
            fix_n  = fix_hi[WIDTH-1];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            count_reg  <= '0;
            signed_reg <= 1'b0;
            is_div_reg <= 1'b0;
            neg_x_reg  <= 1'b0;
            neg_y_reg  <= 1'b0;
            ovf_reg    <= 1'b0;
            a_reg      <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            res_lo_reg <= '0;
            res_hi_reg <= '0;
            carry_reg  <= 1'b0;
            zero_reg   <= 1'b0;
            neg_reg    <= 1'b0;
            over_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        if (bus.op[1] && (bus.reg3 == '0)) begin
                            // Divide by zero skips the iteration entirely.
                            state_reg  <= ST_DONE;
                            res_lo_reg <= '1;
                            res_hi_reg <= bus.reg2;
                            carry_reg  <= 1'b0;
                            zero_reg   <= 1'b0;
                            neg_reg    <= 1'b1;
                            over_reg   <= 1'b1;
                        end else begin
                            state_reg  <= ST_RUN;
                            count_reg  <= CW'(WIDTH-1);
                            signed_reg <= bus.op[0];
                            is_div_reg <= bus.op[1];
                            neg_x_reg  <= in_neg_x;
                            neg_y_reg  <= in_neg_y;
                            ovf_reg    <= (bus.op == OP_DIVS) && (bus.reg2 == MIN_VAL) && (bus.reg3 == '1);
                            a_reg      <= bus.op[1] ? in_y_mag : in_x_mag;
                            lo_reg     <= bus.op[1] ? in_x_mag : in_y_mag;
                            hi_reg     <= '0;
                        end
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (is_div_reg) begin
                        hi_reg <= div_diff[WIDTH] ? rem_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                        lo_reg <= {lo_reg[WIDTH-2:0], ~div_diff[WIDTH]};
                    end else begin
                        hi_reg <= mul_sum[WIDTH:1];
                        lo_reg <= {mul_sum[0], lo_reg[WIDTH-1:1]};
                    end
                    if (count_reg == '0) begin
                        state_reg <= ST_FIX;
                    end else begin
                        count_reg <= count_reg - CW'(1);
                    end
                end
                ST_FIX: begin
                    state_reg  <= ST_DONE;
                    res_lo_reg <= fix_lo;
                    res_hi_reg <= fix_hi;
                    carry_reg  <= fix_c;
                    zero_reg   <= fix_z;
                    neg_reg    <= fix_n;
                    over_reg   <= fix_v;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.ready        = ready_w;
    assign bus.result_valid = (state_reg == ST_DONE);
    assign bus.result_lo    = res_lo_reg;
    assign bus.result_hi    = res_hi_reg;
    assign bus.carry_out    = carry_reg;
    assign bus.zero_out     = zero_reg;
    assign bus.neg_out      = neg_reg;
    assign bus.over_out     = over_reg;
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed-vector bench for alu_muldiv at WIDTH=32: results, flags, latency, handshake, reset abort.
// Latency is counted as the edge at which a clocked consumer first sees result_valid.
module tb_alu_muldiv;
    localparam int W = 32;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [3:0]  f;   // {carry, zero, neg, over}
    } vec_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clock = ~clock;

    alu_muldiv_if #(.WIDTH(W)) bus ();

    alu_muldiv #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    vec_t mul_vecs [5] = '{
        '{2'd0, 32'h0000ffff, 32'h0000ffff, 32'hfffe0001, 32'h00000000, 4'b0000},
        '{2'd1, 32'hffffffff, 32'h00000002, 32'hfffffffe, 32'hffffffff, 4'b0010},
        '{2'd0, 32'hffffffff, 32'hffffffff, 32'h00000001, 32'hfffffffe, 4'b1010},
        '{2'd1, 32'h00000000, 32'hffffffff, 32'h00000000, 32'h00000000, 4'b0100},
        '{2'd1, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 4'b1000}
    };

    vec_t div_vecs [6] = '{
        '{2'd3, 32'hfffffff9, 32'h00000002, 32'hfffffffd, 32'hffffffff, 4'b0010},
        '{2'd2, 32'h00000064, 32'h00000007, 32'h0000000e, 32'h00000002, 4'b0000},
        '{2'd3, 32'h00000007, 32'hfffffffe, 32'hfffffffd, 32'h00000001, 4'b0010},
        '{2'd2, 32'hfffffff9, 32'h00000002, 32'h7ffffffc, 32'h00000001, 4'b0000},
        '{2'd2, 32'h00000005, 32'h00000009, 32'h00000000, 32'h00000005, 4'b0100},
        '{2'd3, 32'hfffffff9, 32'hfffffffe, 32'h00000003, 32'hffffffff, 4'b0000}
    };

    function automatic logic [3:0] flags();
        return {bus.carry_out, bus.zero_out, bus.neg_out, bus.over_out};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one request, then wait (bounded) for result_valid; lat=101 marks a timeout.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int low);
        int n;
        n = 0;
        low = 0;
        while (!bus.ready && n < 100) begin
            tick();
            n++;
        end
        bus.start = 1'b1;
        bus.op    = op;
        bus.reg2  = a;
        bus.reg3  = b;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (!bus.result_valid && n < 100) begin
            if (!bus.ready) low++;
            tick();
            n++;
        end
        lat = n + 1;
        $display("op=%0d a=%h b=%h lo=%h hi=%h cznv=%b lat=%0d", op, a, b,
                 bus.result_lo, bus.result_hi, flags(), lat);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.ready); end
        total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.result_valid); end
        total++; if (bus.result_lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=0", bus.result_lo); end
        total++; if (bus.result_hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=0", bus.result_hi); end
        total++; if (flags() !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", flags()); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_multiply();
        int lat, low;
        for (int i = 0; i < 5; i++) begin
            run_op(mul_vecs[i].op, mul_vecs[i].a, mul_vecs[i].b, lat, low);
            total++; if (lat != 34) begin bad++; $display("FAIL mul%0d_latency got=%0d want=34", i, lat); end
            total++; if (low != 33) begin bad++; $display("FAIL mul%0d_ready_low got=%0d want=33", i, low); end
            total++; if (bus.result_lo !== mul_vecs[i].lo) begin bad++; $display("FAIL mul%0d_lo got=%h want=%h", i, bus.result_lo, mul_vecs[i].lo); end
            total++; if (bus.result_hi !== mul_vecs[i].hi) begin bad++; $display("FAIL mul%0d_hi got=%h want=%h", i, bus.result_hi, mul_vecs[i].hi); end
            total++; if (flags() !== mul_vecs[i].f) begin bad++; $display("FAIL mul%0d_flags got=%b want=%b", i, flags(), mul_vecs[i].f); end
        end
    endtask

    task automatic test_divide();
        int lat, low;
        for (int i = 0; i < 6; i++) begin
            run_op(div_vecs[i].op, div_vecs[i].a, div_vecs[i].b, lat, low);
            total++; if (lat != 34) begin bad++; $display("FAIL div%0d_latency got=%0d want=34", i, lat); end
            total++; if (bus.result_lo !== div_vecs[i].lo) begin bad++; $display("FAIL div%0d_lo got=%h want=%h", i, bus.result_lo, div_vecs[i].lo); end
            total++; if (bus.result_hi !== div_vecs[i].hi) begin bad++; $display("FAIL div%0d_hi got=%h want=%h", i, bus.result_hi, div_vecs[i].hi); end
            total++; if (flags() !== div_vecs[i].f) begin bad++; $display("FAIL div%0d_flags got=%b want=%b", i, flags(), div_vecs[i].f); end
        end
    endtask

    task automatic test_div_zero();
        int lat, low;
        run_op(2'd2, 32'h00000064, 32'h00000000, lat, low);
        total++; if (lat != 1) begin bad++; $display("FAIL divu0_latency got=%0d want=1", lat); end
        total++; if (bus.result_lo !== 32'hffffffff) begin bad++; $display("FAIL divu0_lo got=%h want=ffffffff", bus.result_lo); end
        total++; if (bus.result_hi !== 32'h00000064) begin bad++; $display("FAIL divu0_hi got=%h want=00000064", bus.result_hi); end
        total++; if (flags() !== 4'b0011) begin bad++; $display("FAIL divu0_flags got=%b want=0011", flags()); end
        run_op(2'd3, 32'h80000000, 32'h00000000, lat, low);
        total++; if (lat != 1) begin bad++; $display("FAIL divs0_latency got=%0d want=1", lat); end
        total++; if (bus.result_hi !== 32'h80000000) begin bad++; $display("FAIL divs0_hi got=%h want=80000000", bus.result_hi); end
        total++; if (flags() !== 4'b0011) begin bad++; $display("FAIL divs0_flags got=%b want=0011", flags()); end
    endtask

    task automatic test_div_overflow();
        int lat, low;
        run_op(2'd2, 32'h80000000, 32'hffffffff, lat, low);
        total++; if (bus.result_lo !== 32'h0) begin bad++; $display("FAIL divu_big_lo got=%h want=0", bus.result_lo); end
        total++; if (bus.result_hi !== 32'h80000000) begin bad++; $display("FAIL divu_big_hi got=%h want=80000000", bus.result_hi); end
        total++; if (flags() !== 4'b0100) begin bad++; $display("FAIL divu_big_flags got=%b want=0100", flags()); end
        run_op(2'd3, 32'h80000000, 32'hffffffff, lat, low);
        total++; if (lat != 34) begin bad++; $display("FAIL divs_ovf_latency got=%0d want=34", lat); end
        total++; if (bus.result_lo !== 32'h80000000) begin bad++; $display("FAIL divs_ovf_lo got=%h want=80000000", bus.result_lo); end
        total++; if (bus.result_hi !== 32'h0) begin bad++; $display("FAIL divs_ovf_hi got=%h want=0", bus.result_hi); end
        total++; if (flags() !== 4'b0011) begin bad++; $display("FAIL divs_ovf_flags got=%b want=0011", flags()); end
    endtask

    // Results from the previous operation must persist through IDLE.
    task automatic test_hold();
        for (int i = 0; i < 3; i++) tick();
        total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL hold_valid got=%b want=0", bus.result_valid); end
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL hold_ready got=%b want=1", bus.ready); end
        total++; if (bus.result_lo !== 32'h80000000) begin bad++; $display("FAIL hold_lo got=%h want=80000000", bus.result_lo); end
        total++; if (flags() !== 4'b0011) begin bad++; $display("FAIL hold_flags got=%b want=0011", flags()); end
    endtask

    task automatic test_ignore_busy();
        int n, lat, extra;
        bus.start = 1'b1;
        bus.op    = 2'd2;
        bus.reg2  = 32'h00000064;
        bus.reg3  = 32'h00000007;
        tick();
        bus.op   = 2'd0;
        bus.reg2 = 32'h00000002;
        bus.reg3 = 32'h00000003;
        n = 0;
        while (!bus.result_valid && n < 100) begin
            if (n == 5) bus.start = 1'b0;
            tick();
            n++;
        end
        bus.start = 1'b0;
        lat = n + 1;
        $display("op=2 a=00000064 b=00000007 busy-start lo=%h hi=%h lat=%0d", bus.result_lo, bus.result_hi, lat);
        total++; if (lat != 34) begin bad++; $display("FAIL busy_latency got=%0d want=34", lat); end
        total++; if (bus.result_lo !== 32'h0000000e) begin bad++; $display("FAIL busy_lo got=%h want=0000000e", bus.result_lo); end
        total++; if (bus.result_hi !== 32'h00000002) begin bad++; $display("FAIL busy_hi got=%h want=00000002", bus.result_hi); end
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.result_valid) extra++;
        end
        total++; if (extra != 0) begin bad++; $display("FAIL busy_extra_valid got=%0d want=0", extra); end
    endtask

    // Start held high: first result uses the operands present at the first accept,
    // later ones use the operands changed mid-run; results are 34 cycles apart.
    task automatic test_back_to_back();
        int cnt, prev, n;
        logic [31:0] exp_lo;
        bus.start = 1'b1;
        bus.op    = 2'd0;
        bus.reg2  = 32'd3;
        bus.reg3  = 32'd5;
        tick();
        bus.reg2 = 32'd4;
        cnt  = 0;
        prev = -1;
        for (int i = 0; i <= 110; i++) begin
            if (bus.result_valid) begin
                cnt++;
                exp_lo = (cnt == 1) ? 32'd15 : 32'd20;
                $display("b2b valid #%0d at cycle %0d lo=%h", cnt, i, bus.result_lo);
                total++; if (bus.result_lo !== exp_lo) begin bad++; $display("FAIL b2b%0d_lo got=%h want=%h", cnt, bus.result_lo, exp_lo); end
                if (prev >= 0) begin
                    total++; if (i - prev != 34) begin bad++; $display("FAIL b2b%0d_spacing got=%0d want=34", cnt, i - prev); end
                end
                prev = i;
            end
            tick();
        end
        bus.start = 1'b0;
        total++; if (cnt != 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", cnt); end
        n = 0;
        while (!bus.result_valid && n < 100) begin
            tick();
            n++;
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int lat, low, seen;
        run_op(2'd2, 32'h00000064, 32'h00000007, lat, low);
        bus.start = 1'b1;
        bus.op    = 2'd0;
        bus.reg2  = 32'd3;
        bus.reg3  = 32'd5;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        total++; if (bus.result_lo !== 32'h0000000e) begin bad++; $display("FAIL run_hold_lo got=%h want=0000000e", bus.result_lo); end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b want=1", bus.ready); end
        total++; if (bus.result_lo !== 32'h0) begin bad++; $display("FAIL abort_lo got=%h want=0", bus.result_lo); end
        total++; if (bus.result_hi !== 32'h0) begin bad++; $display("FAIL abort_hi got=%h want=0", bus.result_hi); end
        total++; if (flags() !== 4'b0000) begin bad++; $display("FAIL abort_flags got=%b want=0000", flags()); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.result_valid) seen++;
            tick();
        end
        $display("reset mid-run: valid pulses afterwards=%0d", seen);
        total++; if (seen != 0) begin bad++; $display("FAIL abort_valid got=%0d want=0", seen); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.reg2  = '0;
        bus.reg3  = '0;
        test_reset();
        test_multiply();
        test_divide();
        test_div_zero();
        test_div_overflow();
        test_hold();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
